vga_frame_monitor: RTL and testbench

- Receive-side counterpart of the VGA timing driver.
- Taps the same VGA outputs the FPGA drives (pixel clock, HS, VS, BLANK_N, 8-bit R/G/B), re-derives pixel and line timing, and checks it against the 640x480 mode.
- Reports the bounding box of pixels matching a target colour, giving the game logic and the bench a closed-loop check of the rendered player box.
- Sits in `top` beside the VGA driver and renderer, clocked from `CLOCK_50`.

---
 rtl/vga_frame_monitor.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side checker for a VGA timing stream.
// Re-derives pixel/line/frame timing from the tapped VGA signals, locks after
// LOCK_FRAMES consecutive good frames, and reports the bounding box of pixels
// that match TARGET_RGB.
// Optional feature macro: VGA_MON_CHECKSUM_EN (adds the per-frame frame_chk output).
module vga_frame_monitor #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_TOTAL     = 800,
    parameter int          HS_WIDTH    = 96,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_TOTAL     = 525,
    parameter int          LOCK_FRAMES = 2,
    parameter logic [23:0] TARGET_RGB  = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_clk,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank_n,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] frame_cnt,
    output logic        box_valid,
    output logic        box_found,
    output logic [9:0]  box_x_min,
    output logic [9:0]  box_x_max,
    output logic [9:0]  box_y_min,
    output logic [9:0]  box_y_max
`ifdef VGA_MON_CHECKSUM_EN
    ,
    output logic [15:0] frame_chk
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Line length and HS width are checked as "last index" because the
    // counters restart at 0 on the strobe that closes the line.
    localparam logic [10:0] LP_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] LP_HS_LAST = 11'(HS_WIDTH - 1);
    localparam logic [10:0] LP_WD      = 11'(2 * H_TOTAL);
    localparam logic [9:0]  LP_H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]  LP_V_TOT   = 10'(V_TOTAL);
    localparam logic [9:0]  LP_V_ACT   = 10'(V_ACTIVE);
    localparam logic [7:0]  LP_LOCK    = 8'(LOCK_FRAMES);

    // Saturating increment so runaway counters never wrap into a false match.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // capture stage
    logic        r_vclk, r_vclk_d, r_hs, r_vs, r_bn;
    logic [23:0] r_rgb;
    // strobe-domain state
    logic        r_hs_prev, r_vs_prev, r_frame_bad;
    logic [10:0] r_h_cnt, r_hs_lo;
    logic [9:0]  r_ax, r_ay, r_v_cnt;
    logic        r_hit;
    logic [9:0]  r_run_x_min, r_run_x_max, r_run_y_min, r_run_y_max;
    state_t      r_state;
    logic [7:0]  r_good_cnt;
    // outputs
    logic        r_locked, r_err, r_box_valid, r_box_found;
    logic [15:0] r_frame_cnt;
    logic [9:0]  r_x_min, r_x_max, r_y_min, r_y_max;

    logic        w_pix_en, w_hs_fall, w_vs_fall, w_line_act, w_line_bad;
    logic        w_bad_close, w_frame_good, w_target, w_watchdog, w_emit;
    logic [9:0]  w_v_close, w_ay_close;

    // Register every VGA input once; keep the previous vga_clk for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vclk   <= 1'b0;
            r_vclk_d <= 1'b0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_bn     <= 1'b0;
            r_rgb    <= 24'h000000;
        end else begin
            r_vclk   <= vga_clk;
            r_vclk_d <= r_vclk;
            r_hs     <= hsync;
            r_vs     <= vsync;
            r_bn     <= blank_n;
            r_rgb    <= {r, g, b};
        end
    end

    // Strobe, sync edges, line verdict and the frame verdict as seen at this strobe.
    always_comb begin
        w_pix_en     = r_vclk & ~r_vclk_d;
        w_hs_fall    = r_hs_prev & ~r_hs;
        w_vs_fall    = r_vs_prev & ~r_vs;
        w_line_act   = (r_ax != 10'd0);
        w_line_bad   = (r_h_cnt != LP_H_LAST) || (r_hs_lo != LP_HS_LAST) ||
                       (w_line_act && (r_ax != LP_H_ACT));
        // The line closes before the frame when both syncs fall together.
        w_v_close    = w_hs_fall ? sat_inc10(r_v_cnt) : r_v_cnt;
        w_ay_close   = (w_hs_fall && w_line_act) ? sat_inc10(r_ay) : r_ay;
        w_bad_close  = r_frame_bad | (w_hs_fall & w_line_bad);
        w_frame_good = !w_bad_close && (w_v_close == LP_V_TOT) && (w_ay_close == LP_V_ACT);
        w_target     = r_bn && (r_rgb == TARGET_RGB);
        w_watchdog   = (r_state != ST_SEARCH) && (r_h_cnt >= LP_WD);
        w_emit       = w_pix_en && w_vs_fall && w_frame_good && !w_watchdog &&
                       ((r_state == ST_MEASURE) || (r_state == ST_LOCKED));
    end

    // Pixel/line/frame counters, advancing once per pixel strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs_prev   <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_h_cnt     <= 11'd0;
            r_hs_lo     <= 11'd0;
            r_ax        <= 10'd0;
            r_ay        <= 10'd0;
            r_v_cnt     <= 10'd0;
            r_frame_bad <= 1'b0;
        end else if (w_pix_en) begin
            r_hs_prev <= r_hs;
            r_vs_prev <= r_vs;
            if (w_hs_fall) begin
                r_h_cnt <= 11'd0;
                r_hs_lo <= 11'd0;
                r_ax    <= 10'd0;
            end else begin
                r_h_cnt <= sat_inc11(r_h_cnt);
                r_hs_lo <= r_hs ? r_hs_lo : sat_inc11(r_hs_lo);
                r_ax    <= r_bn ? sat_inc10(r_ax) : r_ax;
            end
            r_v_cnt     <= w_vs_fall ? 10'd0 : w_v_close;
            r_ay        <= w_vs_fall ? 10'd0 : w_ay_close;
            r_frame_bad <= w_vs_fall ? 1'b0 : w_bad_close;
        end
    end

    // Running bounding box of target-coloured active pixels, cleared per frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit       <= 1'b0;
            r_run_x_min <= 10'd0;
            r_run_x_max <= 10'd0;
            r_run_y_min <= 10'd0;
            r_run_y_max <= 10'd0;
        end else if (w_pix_en) begin
            if (w_vs_fall) begin
                r_hit       <= 1'b0;
                r_run_x_min <= 10'd0;
                r_run_x_max <= 10'd0;
                r_run_y_min <= 10'd0;
                r_run_y_max <= 10'd0;
            end else if (w_target) begin
                r_hit       <= 1'b1;
                r_run_x_min <= (!r_hit || (r_ax < r_run_x_min)) ? r_ax : r_run_x_min;
                r_run_x_max <= (!r_hit || (r_ax > r_run_x_max)) ? r_ax : r_run_x_max;
                r_run_y_min <= (!r_hit || (r_ay < r_run_y_min)) ? r_ay : r_run_y_min;
                r_run_y_max <= (!r_hit || (r_ay > r_run_y_max)) ? r_ay : r_run_y_max;
            end
        end
    end

    // Lock state machine: search for a frame start, measure, then supervise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= 8'd0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_pix_en) begin
            if (w_watchdog) begin
                r_state    <= ST_SEARCH;
                r_good_cnt <= 8'd0;
                r_locked   <= 1'b0;
                r_err      <= 1'b1;
            end else if (w_vs_fall) begin
                case (r_state)
                    ST_SEARCH: begin
                        r_state    <= ST_MEASURE;
                        r_good_cnt <= 8'd0;
                    end
                    ST_MEASURE: begin
                        if (!w_frame_good) begin
                            r_good_cnt <= 8'd0;
                        end else if ((r_good_cnt + 8'd1) >= LP_LOCK) begin
                            r_state    <= ST_LOCKED;
                            r_good_cnt <= 8'd0;
                            r_locked   <= 1'b1;
                        end else begin
                            r_good_cnt <= r_good_cnt + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_frame_good) begin
                            r_state  <= ST_SEARCH;
                            r_locked <= 1'b0;
                            r_err    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_SEARCH;
                        r_good_cnt <= 8'd0;
                        r_locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Per-good-frame reporting: count, one-cycle valid pulse, latched box.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= 16'd0;
            r_box_valid <= 1'b0;
            r_box_found <= 1'b0;
            r_x_min     <= 10'd0;
            r_x_max     <= 10'd0;
            r_y_min     <= 10'd0;
            r_y_max     <= 10'd0;
        end else begin
            r_box_valid <= w_emit;
            if (w_emit) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_box_found <= r_hit;
                if (r_hit) begin
                    r_x_min <= r_run_x_min;
                    r_x_max <= r_run_x_max;
                    r_y_min <= r_run_y_min;
                    r_y_max <= r_run_y_max;
                end
            end
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] r_chk, r_frame_chk;

    // Rotating XOR signature over every active pixel, reported for good frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chk       <= 16'h0000;
            r_frame_chk <= 16'h0000;
        end else begin
            if (w_emit) begin
                r_frame_chk <= r_chk;
            end
            if (w_pix_en) begin
                if (w_vs_fall) begin
                    r_chk <= 16'h0000;
                end else if (r_bn) begin
                    r_chk <= {r_chk[14:0], r_chk[15]} ^ {r_rgb[23:16], r_rgb[15:8] ^ r_rgb[7:0]};
                end
            end
        end
    end

    assign frame_chk = r_frame_chk;
`endif

    assign locked     = r_locked;
    assign timing_err = r_err;
    assign frame_cnt  = r_frame_cnt;
    assign box_valid  = r_box_valid;
    assign box_found  = r_box_found;
    assign box_x_min  = r_x_min;
    assign box_x_max  = r_x_max;
    assign box_y_min  = r_y_min;
    assign box_y_max  = r_y_max;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a reduced video mode
// (40 strobes/line, 24 active, HS 6 wide; 30 lines/frame, 20 active).
module tb_vga_frame_monitor;

    localparam int HA = 24;
    localparam int HT = 40;
    localparam int HW = 6;
    localparam int VA = 20;
    localparam int VT = 30;

    logic        clk = 1'b0;
    logic        rst, vga_clk, hsync, vsync, blank_n;
    logic [7:0]  r, g, b;
    logic        locked, timing_err, box_valid, box_found;
    logic [15:0] frame_cnt;
    logic [9:0]  box_x_min, box_x_max, box_y_min, box_y_max;
`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] frame_chk;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int bv_cycles = 0;
    int bv_run    = 0;
    int bv_max    = 0;
    int bv_base   = 0;

    vga_frame_monitor #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_WIDTH(HW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(2), .TARGET_RGB(24'hFFFFFF)
    ) dut (
        .clk(clk), .rst(rst), .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .r(r), .g(g), .b(b),
        .locked(locked), .timing_err(timing_err), .frame_cnt(frame_cnt),
        .box_valid(box_valid), .box_found(box_found),
        .box_x_min(box_x_min), .box_x_max(box_x_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max)
`ifdef VGA_MON_CHECKSUM_EN
        , .frame_chk(frame_chk)
`endif
    );

    always #5 clk = ~clk;

    // Count box_valid high cycles and the longest high run.
    always @(negedge clk) begin
        if (box_valid) begin
            bv_cycles = bv_cycles + 1;
            bv_run    = bv_run + 1;
            if (bv_run > bv_max) bv_max = bv_run;
        end else begin
            bv_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Test picture: 0 black, 1 box A (+ one near-white decoy), 2 box B, 3 corners.
    function automatic logic [23:0] pix_col(input int mode, input int l, input int p);
        logic [23:0] c;
        c = 24'h000000;
        if (mode == 1) begin
            if (p >= 5 && p <= 9 && l >= 3 && l <= 7) c = 24'hFFFFFF;
            else if (l == 10 && p == 20) c = 24'hFFFFFE;
        end else if (mode == 2) begin
            if (p >= 10 && p <= 12 && l >= 1 && l <= 2) c = 24'hFFFFFF;
        end else if (mode == 3) begin
            if ((p == 0 && l == 0) || (p == 23 && l == 19)) c = 24'hFFFFFF;
        end
        return c;
    endfunction

    task automatic strobe(input logic hs, input logic vs, input logic bn, input logic [23:0] rgb);
        @(negedge clk);
        hsync = hs; vsync = vs; blank_n = bn;
        r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
        vga_clk = 1'b1;
        @(negedge clk);
        vga_clk = 1'b0;
    endtask

    // Line timing: active 0..23, HS low 28..33; VS low on lines 22..23.
    task automatic drive_line(input int l, input int p_from, input int p_to, input int mode, input bit extra);
        logic hs, vs, bn;
        for (int p = p_from; p <= p_to; p++) begin
            hs = !(p >= 28 && p <= 33);
            vs = !(l == 22 || l == 23);
            bn = (l < VA) && (p < HA);
            strobe(hs, vs, bn, bn ? pix_col(mode, l, p) : 24'h000000);
            if (extra && p == HT - 1) strobe(hs, vs, 1'b0, 24'h000000);
        end
    endtask

    task automatic drive_frame(input int l_from, input int mode, input bit long_line);
        for (int l = l_from; l < VT; l++) drive_line(l, 0, HT - 1, mode, long_line && (l == 10));
    endtask

    task automatic check_frame(input string tag, input int e_cnt, input int e_lock, input int e_err, input int e_pulses);
        @(negedge clk);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), e_cnt);
        check({tag, "_locked"}, 32'(locked), e_lock);
        check({tag, "_timing_err"}, 32'(timing_err), e_err);
        check({tag, "_pulses"}, 32'(bv_cycles - bv_base), e_pulses);
        bv_base = bv_cycles;
    endtask

    task automatic check_box(input string tag, input int e_found, input int x0, input int x1, input int y0, input int y1);
        check({tag, "_found"}, 32'(box_found), e_found);
        check({tag, "_xmin"}, 32'(box_x_min), x0);
        check({tag, "_xmax"}, 32'(box_x_max), x1);
        check({tag, "_ymin"}, 32'(box_y_min), y0);
        check({tag, "_ymax"}, 32'(box_y_max), y1);
    endtask

    function automatic logic [15:0] chk_model(input int mode);
        logic [15:0] c;
        logic [23:0] px;
        c = 16'h0000;
        for (int l = 0; l < VA; l++) begin
            for (int p = 0; p < HA; p++) begin
                px = pix_col(mode, l, p);
                c = {c[14:0], c[15]} ^ {px[23:16], px[15:8] ^ px[7:0]};
            end
        end
        return c;
    endfunction

    initial begin
        rst = 1'b0; vga_clk = 1'b0; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0;
        r = 8'h00; g = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(timing_err), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_box_valid", 32'(box_valid), 0);
        check_box("rst", 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Acquisition: first close only arms measuring, lock at second good frame.
        drive_frame(0, 0, 1'b0); check_frame("f0", 0, 0, 0, 0);
        drive_frame(0, 0, 1'b0); check_frame("f1", 1, 0, 0, 1);
        check("f1_found", 32'(box_found), 0);
        drive_frame(0, 0, 1'b0); check_frame("f2", 2, 1, 0, 1);
        drive_frame(0, 1, 1'b0); check_frame("f3", 3, 1, 0, 1);
        check_box("f3", 1, 5, 9, 3, 7);
        check("f3_valid_width", 32'(bv_max), 1);
`ifdef VGA_MON_CHECKSUM_EN
        check("f3_chk", 32'(frame_chk), 32'(chk_model(1)));
`endif
        // Black frame: box_found drops, coordinates held.
        drive_frame(0, 0, 1'b0); check_frame("f4", 4, 1, 0, 1);
        check_box("f4", 0, 5, 9, 3, 7);
`ifdef VGA_MON_CHECKSUM_EN
        check("f4_chk", 32'(frame_chk), 0);
`endif
        // One over-long line while locked: bad frame, nothing reported.
        drive_frame(0, 2, 1'b1); check_frame("f5", 4, 0, 1, 0);
        check_box("f5", 0, 5, 9, 3, 7);
        drive_frame(0, 0, 1'b0); check_frame("f6", 4, 0, 1, 0);
        drive_frame(0, 3, 1'b0); check_frame("f7", 5, 0, 1, 1);
        check_box("f7", 1, 0, HA - 1, 0, VA - 1);
        drive_frame(0, 0, 1'b0); check_frame("f8", 6, 1, 1, 1);

        // Asynchronous reset in the middle of a line while locked.
        for (int l = 0; l < 5; l++) drive_line(l, 0, HT - 1, 0, 1'b0);
        drive_line(5, 0, 9, 0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_err", 32'(timing_err), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check("mid_rst_found", 32'(box_found), 0);
        check("mid_rst_xmax", 32'(box_x_max), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bv_base = bv_cycles;
        drive_line(5, 10, HT - 1, 0, 1'b0);
        drive_frame(6, 0, 1'b0); check_frame("r0", 0, 0, 0, 0);
        drive_frame(0, 0, 1'b0); check_frame("r1", 1, 0, 0, 1);
        drive_frame(0, 1, 1'b0); check_frame("r2", 2, 1, 0, 1);
        check_box("r2", 1, 5, 9, 3, 7);

        // HS stops while locked: watchdog after 2*H_TOTAL strobes without a fall.
        drive_line(0, 0, HT - 1, 0, 1'b0);
        repeat (2 * HT - 13) strobe(1'b1, 1'b1, 1'b0, 24'h000000);
        @(negedge clk);
        check("wd_before_locked", 32'(locked), 1);
        check("wd_before_err", 32'(timing_err), 0);
        repeat (4) strobe(1'b1, 1'b1, 1'b0, 24'h000000);
        @(negedge clk);
        check("wd_locked", 32'(locked), 0);
        check("wd_err", 32'(timing_err), 1);
        check("wd_frame_cnt", 32'(frame_cnt), 2);
        check("wd_found", 32'(box_found), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
